imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Instruction-memory programmer that sits on the write side of the 8-bit instruction memory the pipelined core fetches from. It accepts a stream of 8-bit instruction bytes over a valid/ready handshake and writes them to consecutive addresses from 0. It holds the core in reset while loading, then releases it after a fixed settle delay. It owns the writer end of the memory interface that Instruction_Fetch reads.

Parameters:
DEPTH, 32, number of instruction-memory locations writable (1..256)
ADDR_W, 8, width of write address; matches core PC width
HOLD_CYCLES, 4, cycles Core_Reset stays high after the last write before release (>=1)

Ports:
Clk  input  1  system clock, all logic rising-edge
Reset  input  1  synchronous, active-high reset
Load_Start  input  1  single-cycle request to (re)program memory
In_Valid  input  1  In_Data/In_Last valid this cycle
In_Data  input  8  instruction byte
In_Last  input  1  marks final byte of the image
In_Ready  output  1  loader accepts a byte this cycle
Mem_WrEn  output  1  instruction-memory write strobe
Mem_WrAddr  output  ADDR_W  write address
Mem_WrData  output  8  write data
Core_Reset  output  1  reset driven to the processor; high = held
Busy  output  1  LOAD or HOLD state active
Done  output  1  image loaded, core running
Error  output  1  overflow (or checksum failure, with the option enabled)

Behaviour:
- Reset values: state IDLE, Core_Reset=1, In_Ready=0, Mem_WrEn=0, Mem_WrAddr=0, Mem_WrData=0, Busy=0, Done=0, Error=0, internal address counter=0, hold counter=0.
- All outputs are registered. An accepted byte (In_Valid & In_Ready) appears on Mem_WrEn/Addr/Data exactly 1 cycle later as a 1-cycle strobe.
- IDLE: Core_Reset=1. Load_Start → LOAD next cycle, with counter=0.
- LOAD: In_Ready=1, Busy=1, Core_Reset=1. Each accept writes to the counter address, then the counter increments.
  - Accept with In_Last=1 → HOLD, and In_Ready drops the next cycle.
  - Accept at address DEPTH-1 with In_Last=0 → ERROR. That byte is still written.
  - Load_Start is ignored in LOAD. In_Valid is ignored whenever In_Ready=0.
- HOLD: In_Ready=0, Busy=1, Core_Reset=1. Counts HOLD_CYCLES cycles starting the cycle after the final write strobe, then → RUN.
- RUN: Core_Reset=0, Done=1, Busy=0. Load_Start → LOAD; Core_Reset=1 and Done=0 from the next cycle.
- ERROR: Error=1, Core_Reset=1, In_Ready=0. Load_Start clears Error and → LOAD.
- Reset mid-operation returns to IDLE next cycle. Any pending write strobe is cancelled and memory contents are not erased.
- Load_Start and Reset in the same cycle: Reset wins.
- A single-byte image (In_Last on the first accept) is legal: it writes address 0, then HOLD.
- Counter does not wrap. DEPTH=256 overflows at address 255.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - The In_Last byte is a checksum and is not written to memory.
  - The loader keeps a mod-256 sum of all data bytes plus the checksum byte. A nonzero total → ERROR instead of HOLD.
  - Overflow is checked against data bytes only.
  - The check is evaluated in one extra cycle (state CHECK) between LOAD and HOLD.
- Undefined: the In_Last byte is an ordinary instruction; there is no CHECK state and no sum register.

Decomposition:
- Shared package holds the loader state enumeration (IDLE, LOAD, CHECK, HOLD, RUN, ERROR) and the default DEPTH/HOLD_CYCLES constants, so the core top-level and bench share them.
- One natural sub-module: imem_loader_hold_timer, a loadable down-counter with a terminal-count pulse, used for HOLD.

Test Plan:
- Reset then Load_Start; stream 0x41, 0x8A, 0xC3 (last on 0xC3) with In_Valid held high → writes (0,0x41), (1,0x8A), (2,0xC3), one cycle after each accept. Core_Reset falls exactly HOLD_CYCLES=4 cycles after the final strobe; Done=1.
- Stream with In_Valid toggling every other cycle → no writes on idle cycles; addresses stay contiguous 0..N-1.
- DEPTH=32, send 32 bytes with no In_Last → 32 writes, Error=1, In_Ready=0, Core_Reset stays 1. A later Load_Start restarts at address 0 and Error clears.
- Assert Reset during byte 2 of 5 → Mem_WrEn=0 next cycle, state IDLE, Core_Reset=1; further In_Valid is ignored.
- In RUN, pulse Load_Start → Core_Reset=1, Done=0 next cycle. A new 2-byte image writes addresses 0 and 1.
- With IMEM_LOADER_CHECKSUM_EN: bytes 0x10, 0x20, then checksum 0xD0 → two writes, then HOLD. Repeating with checksum 0xD1 → Error=1, no release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// default sizing, used by the loader RTL and its bench alike.
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH       = 32;
    localparam int DEFAULT_ADDR_W      = 8;
    localparam int DEFAULT_HOLD_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    // States from which a Load_Start request begins a fresh image.
    function automatic logic accepts_load_start(loader_state_t s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_hold_timer.sv
// Loadable down-counter for the post-load settle period. After a load it
// counts the enabled cycles down to zero; tc flags the enabled cycle in
// which the count has reached zero.
module imem_loader_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] count;

    // Count register: load wins over decrement, stops at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(HOLD_CYCLES);
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign tc = en && (count == '0);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte stream over valid/ready, writes
// it to consecutive addresses from 0, holds the core in reset while loading
// and releases it after a settle delay.
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to treat the In_Last byte as
// a mod-256 checksum (not written), verified in an extra CHECK state.
//
// Handshake: a byte transfers on a rising edge where In_Valid and In_Ready
// are both high; In_Ready is registered and high only in LOAD, so In_Valid
// is ignored everywhere else. Each transfer that is written shows up on
// Mem_WrEn/Mem_WrAddr/Mem_WrData as a one-cycle strobe in the next cycle.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load_Start,
    input  logic              In_Valid,
    input  logic [7:0]        In_Data,
    input  logic              In_Last,
    output logic              In_Ready,
    output logic              Mem_WrEn,
    output logic [ADDR_W-1:0] Mem_WrAddr,
    output logic [7:0]        Mem_WrData,
    output logic              Core_Reset,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output loader_state_t     Dbg_State
);

    loader_state_t     state;
    loader_state_t     next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;
    logic              write_fire;
    logic              start_load;
    logic              at_last_addr;
    logic              hold_load;
    logic              hold_done;

    logic              in_ready_d;
    logic              core_reset_d;
    logic              busy_d;
    logic              done_d;
    logic              error_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    assign accept       = (state == ST_LOAD) && In_Valid;
    assign start_load   = Load_Start && accepts_load_start(state);
    assign at_last_addr = (wr_ptr == ADDR_W'(DEPTH - 1));
    assign hold_load    = (state != ST_HOLD) && (next_state == ST_HOLD);
    assign Dbg_State    = state;

`ifdef IMEM_LOADER_CHECKSUM_EN
    // The checksum byte is consumed but never written.
    assign write_fire = accept && !In_Last;
`else
    assign write_fire = accept;
`endif

    imem_loader_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (hold_load),
        .en    (state == ST_HOLD),
        .tc    (hold_done)
    );

    // State register; reset overrides any simultaneous Load_Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (Load_Start) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (In_Last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = ST_CHECK;
`else
                        next_state = ST_HOLD;
`endif
                    end else if (at_last_addr) begin
                        next_state = ST_ERROR;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                next_state = (sum == 8'h00) ? ST_HOLD : ST_ERROR;
            end
`endif
            ST_HOLD: begin
                if (hold_done) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (Load_Start) next_state = ST_LOAD;
            end
            ST_ERROR: begin
                if (Load_Start) next_state = ST_LOAD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        in_ready_d   = 1'b0;
        core_reset_d = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        case (next_state)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_CHECK: busy_d = 1'b1;
            ST_HOLD:  busy_d = 1'b1;
            ST_RUN: begin
                core_reset_d = 1'b0;
                done_d       = 1'b1;
            end
            ST_ERROR: error_d = 1'b1;
            default: ;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            In_Ready   <= 1'b0;
            Core_Reset <= 1'b1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            In_Ready   <= in_ready_d;
            Core_Reset <= core_reset_d;
            Busy       <= busy_d;
            Done       <= done_d;
            Error      <= error_d;
        end
    end

    // Write port and address counter; the counter saturates instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Mem_WrEn   <= 1'b0;
            Mem_WrAddr <= '0;
            Mem_WrData <= '0;
            wr_ptr     <= '0;
        end else begin
            Mem_WrEn <= write_fire;
            if (write_fire) begin
                Mem_WrAddr <= wr_ptr;
                Mem_WrData <= In_Data;
            end
            if (start_load) begin
                wr_ptr <= '0;
            end else if (write_fire && !at_last_addr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running mod-256 sum of every accepted byte, checksum included.
    always_ff @(posedge Clk) begin
        if (Reset || start_load) begin
            sum <= 8'h00;
        end else if (accept) begin
            sum <= sum + In_Data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (default DEPTH=32, HOLD_CYCLES=4).
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Load_Start;
    logic          In_Valid;
    logic [7:0]    In_Data;
    logic          In_Last;
    logic          In_Ready;
    logic          Mem_WrEn;
    logic [7:0]    Mem_WrAddr;
    logic [7:0]    Mem_WrData;
    logic          Core_Reset;
    logic          Busy;
    logic          Done;
    logic          Error;
    loader_state_t Dbg_State;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    imem_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load_Start (Load_Start),
        .In_Valid   (In_Valid),
        .In_Data    (In_Data),
        .In_Last    (In_Last),
        .In_Ready   (In_Ready),
        .Mem_WrEn   (Mem_WrEn),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .Core_Reset (Core_Reset),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error),
        .Dbg_State  (Dbg_State)
    );

    // Clock
    always #5 Clk = ~Clk;

    // Scoreboard: every write strobe must match the next expected (addr, data).
    always @(negedge Clk) begin
        if (Mem_WrEn === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", Mem_WrAddr, Mem_WrData);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({Mem_WrAddr, Mem_WrData} !== mon_exp)
                begin
                    errors++;
                    $display("FAIL wr_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                             Mem_WrAddr, Mem_WrData, mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_load;
        Load_Start = 1'b1;
        tick();
        Load_Start = 1'b0;
    endtask

    // Present one byte and wait for it to be taken; leaves In_Valid high.
    task automatic do_accept(input logic [7:0] d, input logic last, input logic [7:0] a, input logic wr);
        int n;
        n = 0;
        In_Valid = 1'b1;
        In_Data  = d;
        In_Last  = last;
        while (In_Ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (In_Ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: got In_Ready=%b, expected 1 within 20 cycles", In_Ready);
        end
        if (wr) exp_q.push_back({a, d});
        tick();
        checks++;
        if (wr) begin
            if (Mem_WrEn !== 1'b1 || Mem_WrAddr !== a || Mem_WrData !== d) begin
                errors++;
                $display("FAIL wr_latency: got en=%b addr=%0d data=%h, expected en=1 addr=%0d data=%h",
                         Mem_WrEn, Mem_WrAddr, Mem_WrData, a, d);
            end
        end else if (Mem_WrEn !== 1'b0) begin
            errors++;
            $display("FAIL wr_suppressed: got en=%b, expected 0", Mem_WrEn);
        end
    endtask

    task automatic wait_run;
        int n;
        n = 0;
        while (Dbg_State !== ST_RUN && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (Dbg_State !== ST_RUN || Core_Reset !== 1'b0 || Done !== 1'b1) begin
            errors++;
            $display("FAIL reach_run: got state=%0d core_reset=%b done=%b, expected RUN 0 1",
                     Dbg_State, Core_Reset, Done);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (Dbg_State !== ST_IDLE || Core_Reset !== 1'b1 || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got state=%0d core_reset=%b in_ready=%b, expected IDLE 1 0",
                     Dbg_State, Core_Reset, In_Ready);
        end
        checks++;
        if (Mem_WrEn !== 1'b0 || Mem_WrAddr !== 8'd0 || Mem_WrData !== 8'd0) begin
            errors++;
            $display("FAIL reset_wr: got en=%b addr=%0d data=%h, expected 0 0 00", Mem_WrEn, Mem_WrAddr, Mem_WrData);
        end
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b error=%b, expected 0 0 0", Busy, Done, Error);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (Dbg_State !== ST_IDLE || Core_Reset !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got state=%0d core_reset=%b, expected IDLE 1", Dbg_State, Core_Reset);
        end
    endtask

    task automatic test_basic;
        pulse_load();
        checks++;
        if (In_Ready !== 1'b1 || Busy !== 1'b1 || Core_Reset !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: got in_ready=%b busy=%b core_reset=%b, expected 1 1 1", In_Ready, Busy, Core_Reset);
        end
        do_accept(8'h41, 1'b0, 8'd0, 1'b1);
        do_accept(8'h8A, 1'b0, 8'd1, 1'b1);
        do_accept(8'hC3, 1'b1, 8'd2, 1'b1);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        checks++;
        if (In_Ready !== 1'b0 || Dbg_State !== ST_HOLD) begin
            errors++;
            $display("FAIL hold_entry: got in_ready=%b state=%0d, expected 0 HOLD", In_Ready, Dbg_State);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (Core_Reset !== 1'b1 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got core_reset=%b busy=%b, expected 1 1", i, Core_Reset, Busy);
            end
        end
        tick();
        checks++;
        if (Core_Reset !== 1'b0 || Done !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL release: got core_reset=%b done=%b busy=%b, expected 0 1 0", Core_Reset, Done, Busy);
        end
    endtask

    task automatic test_toggle;
        logic [7:0] d [4];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_load();
        for (int i = 0; i < 4; i++) begin
            do_accept(d[i], (i == 3), 8'(i), 1'b1);
            In_Valid = 1'b0;
            tick();
            checks++;
            if (Mem_WrEn !== 1'b0) begin
                errors++;
                $display("FAIL toggle_idle%0d: got en=%b, expected 0", i, Mem_WrEn);
            end
        end
        In_Last = 1'b0;
        wait_run();
    endtask

    task automatic test_run_restart;
        pulse_load();
        checks++;
        if (Core_Reset !== 1'b1 || Done !== 1'b0 || Dbg_State !== ST_LOAD) begin
            errors++;
            $display("FAIL run_restart: got core_reset=%b done=%b state=%0d, expected 1 0 LOAD",
                     Core_Reset, Done, Dbg_State);
        end
        do_accept(8'h5A, 1'b0, 8'd0, 1'b1);
        do_accept(8'hA5, 1'b1, 8'd1, 1'b1);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        wait_run();
    endtask

    task automatic test_overflow;
        pulse_load();
        for (int i = 0; i < 32; i++) begin
            do_accept(8'(i * 5 + 1), 1'b0, 8'(i), 1'b1);
        end
        checks++;
        if (Error !== 1'b1 || In_Ready !== 1'b0 || Core_Reset !== 1'b1 || Dbg_State !== ST_ERROR) begin
            errors++;
            $display("FAIL overflow: got error=%b in_ready=%b core_reset=%b state=%0d, expected 1 0 1 ERROR",
                     Error, In_Ready, Core_Reset, Dbg_State);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Mem_WrEn !== 1'b0 || Core_Reset !== 1'b1 || Error !== 1'b1) begin
                errors++;
                $display("FAIL error_stuck%0d: got en=%b core_reset=%b error=%b, expected 0 1 1",
                         i, Mem_WrEn, Core_Reset, Error);
            end
        end
        In_Valid = 1'b0;
        pulse_load();
        checks++;
        if (Error !== 1'b0 || In_Ready !== 1'b1 || Dbg_State !== ST_LOAD) begin
            errors++;
            $display("FAIL error_clear: got error=%b in_ready=%b state=%0d, expected 0 1 LOAD", Error, In_Ready, Dbg_State);
        end
        do_accept(8'h99, 1'b1, 8'd0, 1'b1);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        wait_run();
    endtask

    task automatic test_reset_mid;
        pulse_load();
        do_accept(8'hA0, 1'b0, 8'd0, 1'b1);
        In_Data = 8'hA1;
        Reset   = 1'b1;
        tick();
        checks++;
        if (Mem_WrEn !== 1'b0 || Dbg_State !== ST_IDLE || Core_Reset !== 1'b1 || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got en=%b state=%0d core_reset=%b in_ready=%b, expected 0 IDLE 1 0",
                     Mem_WrEn, Dbg_State, Core_Reset, In_Ready);
        end
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Mem_WrEn !== 1'b0 || In_Ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore_valid%0d: got en=%b in_ready=%b, expected 0 0", i, Mem_WrEn, In_Ready);
            end
        end
        In_Valid   = 1'b0;
        Load_Start = 1'b1;
        Reset      = 1'b1;
        tick();
        checks++;
        if (Dbg_State !== ST_IDLE || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: got state=%0d in_ready=%b, expected IDLE 0", Dbg_State, In_Ready);
        end
        Load_Start = 1'b0;
        Reset      = 1'b0;
        tick();
    endtask

    task automatic test_single_byte;
        pulse_load();
        do_accept(8'h7E, 1'b1, 8'd0, 1'b1);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        checks++;
        if (Dbg_State !== ST_HOLD) begin
            errors++;
            $display("FAIL single_hold: got state=%0d, expected HOLD", Dbg_State);
        end
        wait_run();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_load();
        do_accept(8'h10, 1'b0, 8'd0, 1'b1);
        do_accept(8'h20, 1'b0, 8'd1, 1'b1);
        do_accept(8'hD0, 1'b1, 8'd2, 1'b0);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        checks++;
        if (Dbg_State !== ST_CHECK) begin
            errors++;
            $display("FAIL check_state: got state=%0d, expected CHECK", Dbg_State);
        end
        wait_run();
        pulse_load();
        do_accept(8'h10, 1'b0, 8'd0, 1'b1);
        do_accept(8'h20, 1'b0, 8'd1, 1'b1);
        do_accept(8'hD1, 1'b1, 8'd2, 1'b0);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        tick();
        tick();
        checks++;
        if (Error !== 1'b1 || Core_Reset !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL bad_checksum: got error=%b core_reset=%b done=%b, expected 1 1 0", Error, Core_Reset, Done);
        end
    endtask
`endif

    initial begin
        Reset      = 1'b1;
        Load_Start = 1'b0;
        In_Valid   = 1'b0;
        In_Data    = 8'h00;
        In_Last    = 1'b0;
        test_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_basic();
        test_toggle();
        test_run_restart();
        test_overflow();
        test_reset_mid();
        test_single_byte();
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wr_missing: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
